// File: rtl/alu_arbiter_pkg.sv
// Shared opcode, condition-code and buffer-state definitions for the Y86-64 ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational 64-bit Y86-64 ALU: ADD/SUB/AND/XOR with zero, sign and overflow flags.
module alu_core
  import alu_arbiter_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  // subq rA,rB yields rB-rA, so the subtraction is b + ~a + 1.
  always_comb begin
    res = '0;
    of  = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        res = b + a;
        of  = (a[63] == b[63]) && (res[63] != a[63]);
      end
      ALU_SUB: begin
        res = b + (~a) + 64'd1;
        of  = (a[63] != b[63]) && (res[63] != b[63]);
      end
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end

  assign zf = (res == '0);
  assign sf = res[63];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage and the stack-pointer updater,
// with a registered one-deep result buffer and the architectural CC register.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W       = 64,
  parameter int RST_PTR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_setcc,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_src,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  // last_grant holds the most recently granted index; resetting it to the opposite
  // of RST_PTR gives requester RST_PTR priority on the first contested cycle.
  localparam logic LAST_RST = (RST_PTR == 0);

  buf_state_e   state;
  buf_state_e   state_next;
  logic         last_grant;
  logic         slot_free;
  logic         gnt0;
  logic         gnt1;
  logic         grant;
  logic [1:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         sel_setcc;
  logic [W-1:0] alu_res;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;
  logic [2:0]   cc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The slot can be refilled in the same cycle the consumer drains it.
  always_comb begin
    state_next = state;
    slot_free  = (state == EMPTY) || res_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    grant = gnt0 | gnt1;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (res_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign sel_op    = gnt1 ? req1_op    : req0_op;
  assign sel_a     = gnt1 ? req1_a     : req0_a;
  assign sel_b     = gnt1 ? req1_b     : req0_b;
  assign sel_setcc = gnt1 ? req1_setcc : req0_setcc;

  alu_core u_alu_core (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .res (alu_res),
    .zf  (alu_zf),
    .sf  (alu_sf),
    .of  (alu_of)
  );

  // CC follows the accepting edge, independent of whether the result is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data   <= '0;
      res_src    <= 1'b0;
      last_grant <= LAST_RST;
      cc         <= 3'b001;
    end else if (grant) begin
      res_data   <= alu_res;
      res_src    <= gnt1;
      last_grant <= gnt1;
      if (sel_setcc) begin
        cc[CC_ZF] <= alu_zf;
        cc[CC_SF] <= alu_sf;
        cc[CC_OF] <= alu_of;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign res_valid  = (state == FULL);
  assign cc_zf      = cc[CC_ZF];
  assign cc_sf      = cc[CC_SF];
  assign cc_of      = cc[CC_OF];

endmodule
